// File: rtl/quantser_pkg.sv
// rtl/quantser_pkg.sv - shared types, default precision and qlen clamp for the quantizer/serializer
package quantser_pkg;

  localparam int QS_BQMAX = 16;

  typedef enum logic {IDLE, SHIFT} quantser_state_t;

  // qlen=0 still emits one bit; anything above the maximum precision is capped
  function automatic int clamp_qlen(input int qlen, input int bqmax);
    if (qlen < 1) return 1;
    if (qlen > bqmax) return bqmax;
    return qlen;
  endfunction

endpackage

// File: rtl/quant_saturate.sv
// rtl/quant_saturate.sv - window select + saturate to a left-justified BQMAX-bit code
// QUANTSER_ROUND_EN: round-half-up on the bit below the window instead of truncation
module quant_saturate
  import quantser_pkg::*;
#(
  parameter int BP    = 45,
  parameter int BQMAX = QS_BQMAX,
  parameter int BMSB  = $clog2(BP),
  parameter int BQLEN = $clog2(BQMAX + 1)
) (
  input  logic [BP-1:0]    din,
  input  logic [BMSB-1:0]  msbidx,
  input  logic [BQLEN-1:0] len,
  input  logic             sgn,
  output logic [BQMAX-1:0] code
);

  localparam int W = BP + BQMAX + 1;

  logic [BMSB-1:0]      mi;
  logic signed [W-1:0]  dext;
  logic signed [W-1:0]  q;
  logic signed [W-1:0]  one;
  logic signed [W-1:0]  sat_hi;
  logic signed [W-1:0]  sat_lo;
  logic signed [W-1:0]  umax;
  logic signed [W-1:0]  val;
  int                   s;
`ifdef QUANTSER_ROUND_EN
  logic                 rbit;
`endif

  // Range compare on the scaled value is equivalent to checking the bits above the window
  always_comb begin
    mi     = (int'(msbidx) > BP - 1) ? BMSB'(BP - 1) : msbidx;
    dext   = {{(W-BP){din[BP-1]}}, din};
    one    = W'(1);
    s      = int'(mi) + 1 - int'(len);
    q      = (s >= 0) ? (dext >>> s) : (dext <<< (-s));
`ifdef QUANTSER_ROUND_EN
    rbit   = 1'b0;
    if (s >= 1) rbit = 1'(dext >> (s - 1));
    q      = q + {{(W-1){1'b0}}, rbit};
`endif
    sat_hi = (one <<< (len - BQLEN'(1))) - one;
    sat_lo = -(one <<< (len - BQLEN'(1)));
    umax   = (one <<< len) - one;
    val    = q;
    if (sgn) begin
      if (q > sat_hi)      val = sat_hi;
      else if (q < sat_lo) val = sat_lo;
    end else begin
      if (din[BP-1])       val = '0;
      else if (q > umax)   val = umax;
    end
    code   = BQMAX'(val << (BQMAX - int'(len)));
  end

endmodule

// File: rtl/quantser.sv
// rtl/quantser.sv - quantize one scaled word per handshake and emit it MSB-first bit-serially
// QUANTSER_ROUND_EN selects rounding inside quant_saturate
module quantser
  import quantser_pkg::*;
#(
  parameter int BP    = 45,
  parameter int BQMAX = QS_BQMAX,
  parameter int BMSB  = $clog2(BP),
  parameter int BQLEN = $clog2(BQMAX + 1)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic [BP-1:0]    din,
  input  logic [BMSB-1:0]  msbidx,
  input  logic [BQLEN-1:0] qlen,
  input  logic             sgn,
  output logic             dout,
  output logic             dout_valid,
  output logic             dout_last,
  input  logic             dout_ready
);

  quantser_state_t  state, state_nxt;
  logic [BQMAX-1:0] shreg;
  logic [BQLEN-1:0] cnt;
  logic [BQLEN-1:0] lenq;
  logic [BQMAX-1:0] code;
  logic             take, fin, accept;

  assign lenq = BQLEN'(clamp_qlen(int'(qlen), BQMAX));

  quant_saturate #(
    .BP   (BP),
    .BQMAX(BQMAX),
    .BMSB (BMSB),
    .BQLEN(BQLEN)
  ) u_sat (
    .din   (din),
    .msbidx(msbidx),
    .len   (lenq),
    .sgn   (sgn),
    .code  (code)
  );

  // cnt holds bits remaining after the current one, so last is simply cnt==0
  assign dout_valid = (state == SHIFT);
  assign dout       = dout_valid & shreg[BQMAX-1];
  assign dout_last  = dout_valid && (cnt == '0);
  assign take       = dout_valid && dout_ready;
  assign fin        = take && dout_last;
  assign din_ready  = (state == IDLE) || fin;
  assign accept     = din_valid && din_ready;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SHIFT;
      SHIFT:   if (fin && !accept) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (accept) begin
      shreg <= code;
      cnt   <= lenq - BQLEN'(1);
    end else if (take) begin
      shreg <= {shreg[BQMAX-2:0], 1'b0};
      if (!dout_last) cnt <= cnt - BQLEN'(1);
    end
  end

endmodule

// File: tb/tb_quantser.sv
// tb/tb_quantser.sv - directed self-checking bench for quantser
module tb_quantser;

  logic        clk;
  logic        clr;
  logic        din_valid;
  logic        din_ready;
  logic [44:0] din;
  logic [5:0]  msbidx;
  logic [4:0]  qlen;
  logic        sgn;
  logic        dout;
  logic        dout_valid;
  logic        dout_last;
  logic        dout_ready;

  int n_checks = 0;
  int n_errors = 0;

  quantser dut (
    .clk       (clk),
    .clr       (clr),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .din       (din),
    .msbidx    (msbidx),
    .qlen      (qlen),
    .sgn       (sgn),
    .dout      (dout),
    .dout_valid(dout_valid),
    .dout_last (dout_last),
    .dout_ready(dout_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one word from IDLE, then check every serial bit against exp (left-justified)
  task automatic send(input logic [44:0] d, input logic [5:0] m, input logic [4:0] q,
                      input logic s, input logic [15:0] exp, input int n, input string tag);
    din = d; msbidx = m; qlen = q; sgn = s; din_valid = 1'b1;
    #1 chk({tag, "_rdy"}, 32'(din_ready), 32'd1);
    @(posedge clk); #1;
    din_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      chk({tag, "_vld"},  32'(dout_valid), 32'd1);
      chk({tag, "_bit"},  32'(dout),       32'(exp[15-i]));
      chk({tag, "_last"}, 32'(dout_last),  32'(i == n - 1));
      @(posedge clk); #1;
    end
    chk({tag, "_idle"}, 32'(dout_valid), 32'd0);
  endtask

  int hs;
  int stall;
  logic [15:0] wexp;

  initial begin
    clr = 1'b1; din_valid = 1'b0; din = '0; msbidx = '0; qlen = '0; sgn = 1'b0;
    dout_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_vld",  32'(dout_valid), 32'd0);
    chk("rst_last", 32'(dout_last),  32'd0);
    chk("rst_dout", 32'(dout),       32'd0);
    clr = 1'b0;
    #1 chk("rst_rdy", 32'(din_ready), 32'd1);
    @(posedge clk); #1;

`ifdef QUANTSER_ROUND_EN
    send(45'd300, 6'd9, 5'd4, 1'b0, 16'h5000, 4, "t1");
`else
    send(45'd300, 6'd9, 5'd4, 1'b0, 16'h4000, 4, "t1");
`endif
    send(45'd1000,  6'd7, 5'd8, 1'b0, 16'hFF00, 8, "t2_pu");
    send(45'd1000,  6'd7, 5'd8, 1'b1, 16'h7F00, 8, "t2_ps");
    send(-45'sd1000, 6'd7, 5'd8, 1'b1, 16'h8000, 8, "t2_ns");
    send(-45'sd1000, 6'd7, 5'd8, 1'b0, 16'h0000, 8, "t2_nu");

    // back-to-back: 110 then 101 with din_valid held
    din = 45'd6; msbidx = 6'd2; qlen = 5'd3; sgn = 1'b0; din_valid = 1'b1;
    @(posedge clk); #1;
    din = 45'd5;
    wexp = 16'b110_0000000000000;
    for (int i = 0; i < 3; i++) begin
      chk("t3a_bit",  32'(dout),      32'(wexp[15-i]));
      chk("t3a_last", 32'(dout_last), 32'(i == 2));
      chk("t3a_rdy",  32'(din_ready), 32'(i == 2));
      @(posedge clk); #1;
    end
    din_valid = 1'b0;
    wexp = 16'b101_0000000000000;
    for (int i = 0; i < 3; i++) begin
      chk("t3b_vld",  32'(dout_valid), 32'd1);
      chk("t3b_bit",  32'(dout),       32'(wexp[15-i]));
      chk("t3b_last", 32'(dout_last),  32'(i == 2));
      @(posedge clk); #1;
    end
    chk("t3_idle", 32'(dout_valid), 32'd0);

    // back-pressure: 0xA5 = 10100101, stall 3 cycles after 2nd bit
    din = 45'd165; msbidx = 6'd7; qlen = 5'd8; sgn = 1'b0; din_valid = 1'b1;
    @(posedge clk); #1;
    din_valid = 1'b0;
    wexp = 16'hA500;
    hs = 0; stall = 0;
    for (int c = 0; c < 20 && hs < 8; c++) begin
      if (hs == 2 && stall < 3) begin
        dout_ready = 1'b0;
        #1;
        chk("t4_sbit",  32'(dout),       32'(wexp[13]));
        chk("t4_slast", 32'(dout_last),  32'd0);
        chk("t4_srdy",  32'(din_ready),  32'd0);
        chk("t4_svld",  32'(dout_valid), 32'd1);
        stall++;
      end else begin
        dout_ready = 1'b1;
        #1;
        chk("t4_bit",  32'(dout),      32'(wexp[15-hs]));
        chk("t4_last", 32'(dout_last), 32'(hs == 7));
        chk("t4_rdy",  32'(din_ready), 32'(hs == 7));
        hs++;
      end
      @(posedge clk); #1;
    end
    dout_ready = 1'b1;
    chk("t4_hs",    32'(hs),         32'd8);
    chk("t4_stall", 32'(stall),      32'd3);
    chk("t4_idle",  32'(dout_valid), 32'd0);

    // async clear mid-word
    din = 45'd165; msbidx = 6'd7; qlen = 5'd8; sgn = 1'b0; din_valid = 1'b1;
    @(posedge clk); #1;
    din_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("t5_pre_vld", 32'(dout_valid), 32'd1);
    #1 clr = 1'b1;
    #1;
    chk("t5_vld",  32'(dout_valid), 32'd0);
    chk("t5_last", 32'(dout_last),  32'd0);
    chk("t5_dout", 32'(dout),       32'd0);
    clr = 1'b0;
    @(posedge clk); #1;
`ifdef QUANTSER_ROUND_EN
    send(45'd300, 6'd9, 5'd4, 1'b0, 16'h5000, 4, "t5_next");
`else
    send(45'd300, 6'd9, 5'd4, 1'b0, 16'h4000, 4, "t5_next");
`endif

    send(45'd300,  6'd8,  5'd0,  1'b0, 16'h8000, 1,  "t6_q0");
    send(45'd1000, 6'd20, 5'd20, 1'b0, 16'h001F, 16, "t6_q20");
    send(45'd5,    6'd2,  5'd8,  1'b0, 16'hA000, 8,  "t6_lsh");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
